// File: rtl/zaks32_useq.sv
// ZAKS32 microsequencer: micro-PC, next-address logic, opcode dispatch and microsubroutine stack.
// Optional trace port enabled by defining ZAKS32_USEQ_TRACE_EN.
module zaks32_useq #(
  parameter int                 UPC_W       = 12,
  parameter int                 STACK_DEPTH = 4,
  parameter logic [UPC_W-1:0]   FAULT_VEC   = 12'hFF0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       useq_op,
  input  logic [UPC_W-1:0] useq_addr,
  input  logic [2:0]       cond_sel,
  input  logic             cond_pol,
  input  logic [7:0]       cond_flags,
  input  logic             stall,
  input  logic             ir_valid,
  input  logic [7:0]       ir_opcode,
  output logic             ir_ready,
  input  logic [UPC_W-1:0] dispatch_addr,
  output logic [UPC_W-1:0] upc,
  output logic [7:0]       ir_opcode_q,
  output logic             ufault,
  output logic             trace_valid,
  output logic [UPC_W-1:0] trace_upc,
  output logic [7:0]       trace_opcode
);

  typedef enum logic [2:0] {
    OP_CONT  = 3'd0,
    OP_JMP   = 3'd1,
    OP_CJMP  = 3'd2,
    OP_DISP  = 3'd3,
    OP_CALL  = 3'd4,
    OP_RET   = 3'd5,
    OP_FETCH = 3'd6,
    OP_WAIT  = 3'd7
  } useq_op_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_e;

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  state_e           state, state_nxt;
  logic [SP_W-1:0]  sp, sp_nxt;
  logic [UPC_W-1:0] upc_nxt, upc_inc;
  logic [7:0]       opq_nxt;
  logic             cond;
  logic             push;
  logic [IDX_W-1:0] push_idx, pop_idx;

  // NOTE: the stack array has no reset; only sp is reset, which makes every entry invalid.
  logic [UPC_W-1:0] stack [2**IDX_W];

  assign cond     = cond_flags[cond_sel] ^ cond_pol;
  assign upc_inc  = upc + 1'b1;
  assign push_idx = sp[IDX_W-1:0];
  assign pop_idx  = IDX_W'(sp - 1'b1);
  assign ufault   = (state == ST_FAULT);
  assign ir_ready = (state == ST_RUN) && (useq_op == OP_DISP) && !stall && rst;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    sp_nxt    = sp;
    upc_nxt   = upc;
    opq_nxt   = ir_opcode_q;
    push      = 1'b0;
    if (state == ST_FAULT) begin
      upc_nxt = FAULT_VEC;
    end else if (!stall) begin
      unique case (useq_op_e'(useq_op))
        OP_CONT:  upc_nxt = upc_inc;
        OP_JMP:   upc_nxt = useq_addr;
        OP_CJMP:  upc_nxt = cond ? useq_addr : upc_inc;
        OP_DISP: begin
          if (ir_valid) begin
            upc_nxt = dispatch_addr;
            opq_nxt = ir_opcode;
          end
        end
        OP_CALL: begin
          if (sp == SP_W'(STACK_DEPTH)) begin
            state_nxt = ST_FAULT;
            upc_nxt   = FAULT_VEC;
          end else begin
            push    = 1'b1;
            sp_nxt  = sp + 1'b1;
            upc_nxt = useq_addr;
          end
        end
        OP_RET: begin
          if (sp == '0) begin
            state_nxt = ST_FAULT;
            upc_nxt   = FAULT_VEC;
          end else begin
            sp_nxt  = sp - 1'b1;
            upc_nxt = stack[pop_idx];
          end
        end
        OP_FETCH: upc_nxt = '0;
        OP_WAIT:  upc_nxt = cond ? upc_inc : upc;
        default:  upc_nxt = upc;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_RUN;
      sp          <= '0;
      upc         <= '0;
      ir_opcode_q <= 8'h00;
    end else begin
      state       <= state_nxt;
      sp          <= sp_nxt;
      upc         <= upc_nxt;
      ir_opcode_q <= opq_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) stack[push_idx] <= upc_inc;
  end

`ifdef ZAKS32_USEQ_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      trace_valid  <= 1'b0;
      trace_upc    <= '0;
      trace_opcode <= 8'h00;
    end else if ((state == ST_RUN) && !stall) begin
      trace_valid  <= 1'b1;
      trace_upc    <= upc;
      trace_opcode <= ir_opcode_q;
    end else begin
      trace_valid  <= 1'b0;
    end
  end
`else
  assign trace_valid  = 1'b0;
  assign trace_upc    = '0;
  assign trace_opcode = 8'h00;
`endif

endmodule

// File: tb/tb_zaks32_useq.sv
// Directed self-checking bench for zaks32_useq; the bench plays the control store,
// driving each microword's next-address fields cycle by cycle.
module tb_zaks32_useq;

  localparam int UPC_W = 12;

  localparam logic [2:0] CONT = 3'd0, JMP = 3'd1, CJMP = 3'd2, DISP = 3'd3,
                         CALL = 3'd4, RET = 3'd5, FETCH = 3'd6, WAIT = 3'd7;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       useq_op;
  logic [UPC_W-1:0] useq_addr;
  logic [2:0]       cond_sel;
  logic             cond_pol;
  logic [7:0]       cond_flags;
  logic             stall;
  logic             ir_valid;
  logic [7:0]       ir_opcode;
  logic             ir_ready;
  logic [UPC_W-1:0] dispatch_addr;
  logic [UPC_W-1:0] upc;
  logic [7:0]       ir_opcode_q;
  logic             ufault;
  logic             trace_valid;
  logic [UPC_W-1:0] trace_upc;
  logic [7:0]       trace_opcode;

  int tests = 0;
  int fails = 0;

  zaks32_useq dut (
    .clk(clk), .rst(rst), .useq_op(useq_op), .useq_addr(useq_addr),
    .cond_sel(cond_sel), .cond_pol(cond_pol), .cond_flags(cond_flags),
    .stall(stall), .ir_valid(ir_valid), .ir_opcode(ir_opcode), .ir_ready(ir_ready),
    .dispatch_addr(dispatch_addr), .upc(upc), .ir_opcode_q(ir_opcode_q),
    .ufault(ufault), .trace_valid(trace_valid), .trace_upc(trace_upc),
    .trace_opcode(trace_opcode)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle past it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one microword, then clock it.
  task automatic uop(input logic [2:0] op, input logic [UPC_W-1:0] addr);
    useq_op   = op;
    useq_addr = addr;
    cyc();
  endtask

  initial begin
    rst = 1'b0; useq_op = DISP; useq_addr = '0; cond_sel = 3'd2; cond_pol = 1'b0;
    cond_flags = 8'h00; stall = 1'b0; ir_valid = 1'b1; ir_opcode = 8'hEE;
    dispatch_addr = 12'h777;
    cyc(); cyc();
    check("rst_upc", 32'(upc), 32'h000);
    check("rst_ufault", 32'(ufault), 32'h0);
    check("rst_opq", 32'(ir_opcode_q), 32'h00);
    check("rst_ready", 32'(ir_ready), 32'h0);
    check("rst_trace_valid", 32'(trace_valid), 32'h0);

    // NOP flow: opcode 0x00 maps to 0x001, which is FETCH.
    rst = 1'b1; ir_opcode = 8'h00; dispatch_addr = 12'h001;
    #1;
    check("nop_ready_at_0", 32'(ir_ready), 32'h1);
    cyc();
    check("nop_upc_1", 32'(upc), 32'h001);
    check("nop_opq", 32'(ir_opcode_q), 32'h00);
`ifdef ZAKS32_USEQ_TRACE_EN
    check("trace_valid_on", 32'(trace_valid), 32'h1);
    check("trace_upc_prev", 32'(trace_upc), 32'h000);
`else
    check("trace_tied_valid", 32'(trace_valid), 32'h0);
    check("trace_tied_upc", 32'(trace_upc), 32'h000);
`endif
    useq_op = FETCH; ir_valid = 1'b0;
    #1;
    check("nop_ready_at_1", 32'(ir_ready), 32'h0);
    uop(FETCH, 12'h000);
    check("nop_upc_back", 32'(upc), 32'h000);

    // Dispatch backpressure: three empty cycles, then 0x5A -> 0x2A0.
    ir_valid = 1'b0; ir_opcode = 8'h5A; dispatch_addr = 12'h2A0;
    for (int i = 0; i < 3; i++) begin
      uop(DISP, 12'h000);
      check("bp_hold", 32'(upc), 32'h000);
    end
    ir_valid = 1'b1;
    uop(DISP, 12'h000);
    check("bp_upc", 32'(upc), 32'h2A0);
    check("bp_opq", 32'(ir_opcode_q), 32'h5A);

    // Stall during DISP with a valid opcode: nothing moves.
    stall = 1'b1; ir_opcode = 8'h33; dispatch_addr = 12'h123; useq_op = DISP;
    #1;
    check("stall_ready", 32'(ir_ready), 32'h0);
    uop(DISP, 12'h000);
    check("stall_upc", 32'(upc), 32'h2A0);
    check("stall_opq", 32'(ir_opcode_q), 32'h5A);
    stall = 1'b0; ir_valid = 1'b0;

    // Call nesting.
    uop(JMP, 12'h010);
    check("jmp_upc", 32'(upc), 32'h010);
    uop(CALL, 12'h100); check("call1", 32'(upc), 32'h100);
    uop(CALL, 12'h200); check("call2", 32'(upc), 32'h200);
    uop(RET, 12'h000);  check("ret1", 32'(upc), 32'h101);
    uop(RET, 12'h000);  check("ret2", 32'(upc), 32'h011);
    check("nest_ufault", 32'(ufault), 32'h0);

    // CJMP and WAIT on flag bit 2.
    cond_flags = 8'h04; cond_sel = 3'd2; cond_pol = 1'b0;
    uop(CJMP, 12'h300); check("cjmp_taken", 32'(upc), 32'h300);
    cond_pol = 1'b1;
    uop(CJMP, 12'h555); check("cjmp_not_taken", 32'(upc), 32'h301);
    cond_pol = 1'b0; cond_flags = 8'hFB;
    uop(WAIT, 12'h000); check("wait_hold1", 32'(upc), 32'h301);
    uop(WAIT, 12'h000); check("wait_hold2", 32'(upc), 32'h301);
    cond_flags = 8'h04;
    uop(WAIT, 12'h000); check("wait_release", 32'(upc), 32'h302);

    // Wrap at the top of the microaddress space.
    uop(JMP, 12'hFFF); check("jmp_fff", 32'(upc), 32'hFFF);
    uop(CONT, 12'h000); check("cont_wrap", 32'(upc), 32'h000);

    // Overflow: four CALLs fill the stack, the fifth faults.
    uop(CALL, 12'h400); uop(CALL, 12'h500); uop(CALL, 12'h600); uop(CALL, 12'h700);
    check("call4_upc", 32'(upc), 32'h700);
    check("call4_ufault", 32'(ufault), 32'h0);
    uop(CALL, 12'h800);
    check("ovf_upc", 32'(upc), 32'hFF0);
    check("ovf_ufault", 32'(ufault), 32'h1);
    useq_op = DISP; ir_valid = 1'b1;
    #1;
    check("fault_ready", 32'(ir_ready), 32'h0);
    uop(JMP, 12'h123);
    check("fault_ignores_jmp", 32'(upc), 32'hFF0);
    stall = 1'b1;
    uop(RET, 12'h000);
    check("fault_stall", 32'(upc), 32'hFF0);
    check("fault_sticky", 32'(ufault), 32'h1);
    stall = 1'b0; ir_valid = 1'b0;

    // Reset clears the fault; reset mid-CALL chain empties the stack.
    rst = 1'b0; uop(CONT, 12'h000);
    check("rst2_upc", 32'(upc), 32'h000);
    check("rst2_ufault", 32'(ufault), 32'h0);
    rst = 1'b1;
    uop(CALL, 12'h050); check("call_after_rst", 32'(upc), 32'h050);
    uop(CALL, 12'h060); check("call_after_rst2", 32'(upc), 32'h060);
    rst = 1'b0; uop(CALL, 12'h070);
    check("rst3_upc", 32'(upc), 32'h000);
    check("rst3_ufault", 32'(ufault), 32'h0);
    rst = 1'b1;
    uop(RET, 12'h000);
    check("udf_upc", 32'(upc), 32'hFF0);
    check("udf_ufault", 32'(ufault), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
